implication_monitor: RTL and testbench



---
 rtl/implication_pkg.sv | 22 ++
 rtl/implication_monitor_if.sv | 29 ++
 rtl/implication_channel.sv | 74 +++++++
 rtl/implication_monitor.sv | 57 +++++
 tb/tb_implication_monitor.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/implication_pkg.sv
// Shared constants and parameter checking for the bounded-delay implication monitor.
package implication_pkg;

   // Largest supported window end; one pending flop per age up to this limit.
   localparam int MAX_DELAY_LIMIT = 31;

   // Default width of each per-channel failure counter.
   localparam int CNT_W_DEFAULT = 8;

   // True when the parameter set describes a legal monitor.
   function automatic bit check_params(input int channels,
                                       input int min_delay,
                                       input int max_delay,
                                       input int cnt_w);
      return (channels >= 1) &&
             (min_delay >= 0) &&
             (min_delay <= max_delay) &&
             (max_delay <= MAX_DELAY_LIMIT) &&
             (cnt_w >= 1);
   endfunction

endpackage : implication_pkg

// File: rtl/implication_monitor_if.sv
// Signal bundle between the observed design (master) and the implication monitor (slave).
interface implication_monitor_if
   import implication_pkg::*;
#(
   parameter int CHANNELS = 1,
   parameter int CNT_W    = CNT_W_DEFAULT
) ();

   logic                      en;
   logic [CHANNELS-1:0]       antecedent;
   logic [CHANNELS-1:0]       consequent;
   logic [CHANNELS-1:0]       pass;
   logic [CHANNELS-1:0]       fail;
   logic [CHANNELS*CNT_W-1:0] fail_count;
   logic                      error;

   // Side that produces the observed events and consumes the verdicts.
   modport master (
      output en, antecedent, consequent,
      input  pass, fail, fail_count, error
   );

   // The monitor itself.
   modport slave (
      input  en, antecedent, consequent,
      output pass, fail, fail_count, error
   );

endinterface : implication_monitor_if

// File: rtl/implication_channel.sv
// One channel of the implication monitor: attempt ageing, discharge, expiry and failure count.
module implication_channel
   import implication_pkg::*;
#(
   parameter int MIN_DELAY = 0,
   parameter int MAX_DELAY = 1,
   parameter int CNT_W     = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             antecedent,
   input  logic             consequent,
   output logic             pass,
   output logic             fail,
   output logic [CNT_W-1:0] fail_count,
   output logic             expire
);

   // Bit k is an attempt of age k; bit 0 is the attempt starting this cycle.
   logic [MAX_DELAY:0] age_vec;
   logic [MAX_DELAY:0] live;
   logic [MAX_DELAY:0] dis;
   logic [MAX_DELAY:0] survive;

   if (MAX_DELAY > 0) begin : g_pend
      logic [MAX_DELAY:1] pend_q;

      // Age surviving attempts by one slot; en low has already cleared them via live.
      always_ff @(posedge clk) begin
         // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
         if (rst) begin
            pend_q <= '0;
         end else begin
            pend_q <= survive[MAX_DELAY-1:0];
         end
      end

      assign age_vec = {pend_q, antecedent};
   end else begin : g_no_pend
      // Zero-length window: every attempt resolves in the cycle it starts.
      assign age_vec = antecedent;
   end

   // Mask by enable, discharge everything in the window, flag what falls off the end.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      live    = '0;
      dis     = '0;
      survive = '0;
      live    = age_vec & {(MAX_DELAY + 1){en}};
      for (int k = 0; k <= MAX_DELAY; k++) begin
         dis[k] = live[k] & consequent & (k >= MIN_DELAY);
      end
      survive = live & ~dis;
      expire  = survive[MAX_DELAY];
   end

   // Register the verdict pulses and keep a saturating failure count.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass       <= 1'b0;
         fail       <= 1'b0;
         fail_count <= '0;
      end else begin
         pass <= |dis;
         fail <= expire;
         if (expire && (fail_count != '1)) begin
            fail_count <= fail_count + CNT_W'(1);
         end
      end
   end

endmodule : implication_channel

// File: rtl/implication_monitor.sv
// Multi-channel checker for antecedent |-> ##[MIN_DELAY:MAX_DELAY] consequent.
module implication_monitor
   import implication_pkg::*;
#(
   parameter int CHANNELS  = 1,
   parameter int MIN_DELAY = 0,
   parameter int MAX_DELAY = 1,
   parameter int CNT_W     = CNT_W_DEFAULT
) (
   input logic                 clk,
   input logic                 rst,
   implication_monitor_if.slave bus
);

   if (!check_params(CHANNELS, MIN_DELAY, MAX_DELAY, CNT_W)) begin : g_param_check
      $error("implication_monitor: need CHANNELS>=1, 0<=MIN_DELAY<=MAX_DELAY<=31, CNT_W>=1");
   end

   logic [CHANNELS-1:0]       pass_w;
   logic [CHANNELS-1:0]       fail_w;
   logic [CHANNELS-1:0]       expire_w;
   logic [CHANNELS*CNT_W-1:0] count_w;
   logic                      error_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      implication_channel #(
         .MIN_DELAY (MIN_DELAY),
         .MAX_DELAY (MAX_DELAY),
         .CNT_W     (CNT_W)
      ) u_channel (
         .clk        (clk),
         .rst        (rst),
         .en         (bus.en),
         .antecedent (bus.antecedent[i]),
         .consequent (bus.consequent[i]),
         .pass       (pass_w[i]),
         .fail       (fail_w[i]),
         .fail_count (count_w[i*CNT_W +: CNT_W]),
         .expire     (expire_w[i])
      );
   end

   // Sticky error rises on the same edge that registers any channel's fail pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         error_q <= 1'b0;
      end else if (|expire_w) begin
         error_q <= 1'b1;
      end
   end

   assign bus.pass       = pass_w;
   assign bus.fail       = fail_w;
   assign bus.fail_count = count_w;
   assign bus.error      = error_q;

endmodule : implication_monitor

// File: tb/tb_implication_monitor.sv
// Self-checking bench: five monitor configurations against an attempt-list reference model.
module tb_implication_monitor;

   localparam int NDUT = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] ant;
   logic [1:0] cons;

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // DUT configurations: A 0..0, B 1..3, C 2..2, D 1..4, E two channels 0..1 with 2-bit counters.
   int pmin[NDUT]  = '{0, 1, 2, 1, 0};
   int pmax[NDUT]  = '{0, 3, 2, 4, 1};
   int pch[NDUT]   = '{1, 1, 1, 1, 2};
   int pcmax[NDUT] = '{255, 255, 255, 255, 3};

   implication_monitor_if #(.CHANNELS(1), .CNT_W(8)) if_a ();
   implication_monitor_if #(.CHANNELS(1), .CNT_W(8)) if_b ();
   implication_monitor_if #(.CHANNELS(1), .CNT_W(8)) if_c ();
   implication_monitor_if #(.CHANNELS(1), .CNT_W(8)) if_d ();
   implication_monitor_if #(.CHANNELS(2), .CNT_W(2)) if_e ();

   assign if_a.en = en;  assign if_a.antecedent = ant[0];  assign if_a.consequent = cons[0];
   assign if_b.en = en;  assign if_b.antecedent = ant[0];  assign if_b.consequent = cons[0];
   assign if_c.en = en;  assign if_c.antecedent = ant[0];  assign if_c.consequent = cons[0];
   assign if_d.en = en;  assign if_d.antecedent = ant[0];  assign if_d.consequent = cons[0];
   assign if_e.en = en;  assign if_e.antecedent = ant;     assign if_e.consequent = cons;

   implication_monitor #(.CHANNELS(1), .MIN_DELAY(0), .MAX_DELAY(0), .CNT_W(8))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   implication_monitor #(.CHANNELS(1), .MIN_DELAY(1), .MAX_DELAY(3), .CNT_W(8))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));
   implication_monitor #(.CHANNELS(1), .MIN_DELAY(2), .MAX_DELAY(2), .CNT_W(8))
      dut_c (.clk(clk), .rst(rst), .bus(if_c));
   implication_monitor #(.CHANNELS(1), .MIN_DELAY(1), .MAX_DELAY(4), .CNT_W(8))
      dut_d (.clk(clk), .rst(rst), .bus(if_d));
   implication_monitor #(.CHANNELS(2), .MIN_DELAY(0), .MAX_DELAY(1), .CNT_W(2))
      dut_e (.clk(clk), .rst(rst), .bus(if_e));

   // Uniform view of every DUT's outputs.
   logic [1:0] act_pass[NDUT];
   logic [1:0] act_fail[NDUT];
   logic [7:0] act_cnt[NDUT][2];
   logic       act_err[NDUT];

   assign act_pass[0] = {1'b0, if_a.pass};  assign act_fail[0] = {1'b0, if_a.fail};
   assign act_pass[1] = {1'b0, if_b.pass};  assign act_fail[1] = {1'b0, if_b.fail};
   assign act_pass[2] = {1'b0, if_c.pass};  assign act_fail[2] = {1'b0, if_c.fail};
   assign act_pass[3] = {1'b0, if_d.pass};  assign act_fail[3] = {1'b0, if_d.fail};
   assign act_pass[4] = if_e.pass;          assign act_fail[4] = if_e.fail;
   assign act_cnt[0][0] = if_a.fail_count;  assign act_cnt[0][1] = 8'd0;
   assign act_cnt[1][0] = if_b.fail_count;  assign act_cnt[1][1] = 8'd0;
   assign act_cnt[2][0] = if_c.fail_count;  assign act_cnt[2][1] = 8'd0;
   assign act_cnt[3][0] = if_d.fail_count;  assign act_cnt[3][1] = 8'd0;
   assign act_cnt[4][0] = {6'd0, if_e.fail_count[1:0]};
   assign act_cnt[4][1] = {6'd0, if_e.fail_count[3:2]};
   assign act_err[0] = if_a.error;  assign act_err[1] = if_b.error;
   assign act_err[2] = if_c.error;  assign act_err[3] = if_d.error;
   assign act_err[4] = if_e.error;

   // Reference model: a list of live attempt ages per DUT channel (index dut*2+ch).
   int ages[NDUT*2][$];
   bit m_pass[NDUT][2];
   bit m_fail[NDUT][2];
   int m_cnt[NDUT][2];
   bit m_err[NDUT];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Predict the outputs after the coming edge from this cycle's inputs.
   task automatic model_step(input logic [1:0] a, input logic [1:0] c, input logic e, input logic r);
      for (int d = 0; d < NDUT; d++) begin
         if (r) m_err[d] = 1'b0;
         for (int ch = 0; ch < pch[d]; ch++) begin
            int idx = d * 2 + ch;
            if (r) begin
               ages[idx].delete();
               m_pass[d][ch] = 1'b0;
               m_fail[d][ch] = 1'b0;
               m_cnt[d][ch]  = 0;
            end else if (!e) begin
               ages[idx].delete();
               m_pass[d][ch] = 1'b0;
               m_fail[d][ch] = 1'b0;
            end else begin
               int nxt[$];
               bit hit = 1'b0;
               bit gone = 1'b0;
               if (a[ch]) ages[idx].push_back(0);
               for (int i = 0; i < ages[idx].size(); i++) begin
                  int age = ages[idx][i];
                  if (c[ch] && age >= pmin[d] && age <= pmax[d]) hit = 1'b1;
                  else if (age == pmax[d]) gone = 1'b1;
                  else nxt.push_back(age + 1);
               end
               ages[idx] = nxt;
               m_pass[d][ch] = hit;
               m_fail[d][ch] = gone;
               if (gone) begin
                  if (m_cnt[d][ch] < pcmax[d]) m_cnt[d][ch]++;
                  m_err[d] = 1'b1;
               end
            end
         end
      end
   endtask

   // Apply one cycle of inputs, then compare every DUT with the model just after the edge.
   task automatic cycle(input logic [1:0] a, input logic [1:0] c, input logic e, input logic r);
      logic [20:0] act_v;
      logic [20:0] exp_v;
      ant  = a;
      cons = c;
      en   = e;
      rst  = r;
      model_step(a, c, e, r);
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
         act_v = {act_err[d], act_pass[d], act_fail[d], act_cnt[d][1], act_cnt[d][0]};
         exp_v = {m_err[d], m_pass[d][1], m_pass[d][0], m_fail[d][1], m_fail[d][0],
                  8'(m_cnt[d][1]), 8'(m_cnt[d][0])};
         check($sformatf("model dut%0d cyc%0d", d, cyc), 32'(act_v), 32'(exp_v));
      end
   endtask

   task automatic reset_all();
      cycle(2'b00, 2'b00, 1'b1, 1'b1);
      cycle(2'b00, 2'b00, 1'b1, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, 1'b1, 1'b0);
   endtask

   typedef struct {
      logic       a;
      logic       c;
      logic       e;
      logic       exp_pass;
      logic       exp_fail;
      logic [7:0] exp_cnt;
      logic       exp_err;
   } vec_t;

   vec_t tbl[8];

   initial begin
      // Zero-length window vectors for DUT A; each row resolves in one cycle.
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1};

      ant  = 2'b00;
      cons = 2'b00;
      en   = 1'b1;
      rst  = 1'b1;

      reset_all();
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("reset outputs dut%0d", d),
               32'({act_err[d], act_pass[d], act_fail[d], act_cnt[d][1], act_cnt[d][0]}), 32'd0);
      end

      for (int i = 0; i < 8; i++) begin
         cycle({1'b0, tbl[i].a}, {1'b0, tbl[i].c}, tbl[i].e, 1'b0);
         check($sformatf("A row%0d pass", i), 32'(act_pass[0][0]), 32'(tbl[i].exp_pass));
         check($sformatf("A row%0d fail", i), 32'(act_fail[0][0]), 32'(tbl[i].exp_fail));
         check($sformatf("A row%0d cnt/err", i), 32'({act_err[0], act_cnt[0][0]}),
               32'({tbl[i].exp_err, tbl[i].exp_cnt}));
      end

      // B (1..3): consequent in the antecedent's own cycle is too early; attempt fails at t+4.
      reset_all();
      cycle(2'b01, 2'b01, 1'b1, 1'b0);
      check("B early consequent no pass", 32'(act_pass[1][0]), 32'd0);
      idle(2);
      check("B no fail before window end", 32'(act_fail[1][0]), 32'd0);
      idle(1);
      check("B fail at t+4", 32'({act_fail[1][0], act_cnt[1][0]}), 32'({1'b1, 8'd1}));
      idle(2);
      cycle(2'b01, 2'b00, 1'b1, 1'b0);
      idle(2);
      cycle(2'b00, 2'b01, 1'b1, 1'b0);
      check("B pass at window end", 32'({act_pass[1][0], act_fail[1][0]}), 32'({1'b1, 1'b0}));

      // B: three stacked attempts discharged by one consequent.
      reset_all();
      cycle(2'b01, 2'b00, 1'b1, 1'b0);
      cycle(2'b01, 2'b00, 1'b1, 1'b0);
      cycle(2'b01, 2'b00, 1'b1, 1'b0);
      cycle(2'b00, 2'b01, 1'b1, 1'b0);
      check("B shared discharge pass", 32'(act_pass[1][0]), 32'd1);
      idle(1);
      check("B single pass pulse", 32'(act_pass[1][0]), 32'd0);
      idle(4);
      check("B no fail after shared discharge", 32'({act_err[1], act_cnt[1][0]}), 32'd0);

      // C (2..2): second attempt is too young for the consequent and fails next cycle.
      reset_all();
      cycle(2'b01, 2'b00, 1'b1, 1'b0);
      cycle(2'b01, 2'b00, 1'b1, 1'b0);
      cycle(2'b00, 2'b01, 1'b1, 1'b0);
      check("C pass first attempt", 32'({act_pass[2][0], act_fail[2][0]}), 32'({1'b1, 1'b0}));
      idle(1);
      check("C fail second attempt", 32'({act_fail[2][0], act_cnt[2][0]}), 32'({1'b1, 8'd1}));

      // D (1..4): reset in flight drops the attempt silently.
      reset_all();
      cycle(2'b01, 2'b00, 1'b1, 1'b0);
      idle(1);
      cycle(2'b00, 2'b00, 1'b1, 1'b1);
      check("D outputs zero after reset", 32'({act_err[3], act_pass[3][0], act_fail[3][0], act_cnt[3][0]}), 32'd0);
      idle(6);
      check("D no fail after reset drop", 32'({act_err[3], act_cnt[3][0]}), 32'd0);

      // D: enable low drops the attempt but keeps the existing count and error.
      reset_all();
      cycle(2'b01, 2'b00, 1'b1, 1'b0);
      idle(4);
      check("D plain fail at t+5", 32'({act_fail[3][0], act_cnt[3][0]}), 32'({1'b1, 8'd1}));
      idle(1);
      cycle(2'b01, 2'b00, 1'b1, 1'b0);
      idle(1);
      cycle(2'b00, 2'b00, 1'b0, 1'b0);
      idle(6);
      check("D en-low drop keeps count", 32'({act_err[3], act_fail[3][0], act_cnt[3][0]}),
            32'({1'b1, 1'b0, 8'd1}));

      // E: four back-to-back failures on channel 1 saturate its 2-bit counter.
      reset_all();
      for (int i = 0; i < 4; i++) cycle(2'b10, 2'b00, 1'b1, 1'b0);
      idle(2);
      check("E ch1 saturated", 32'(act_cnt[4][1]), 32'd3);
      check("E ch0 untouched", 32'(act_cnt[4][0]), 32'd0);
      check("E error sticky", 32'(act_err[4]), 32'd1);

      // Randomised traffic, including en drops and occasional resets.
      reset_all();
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] a;
         logic [1:0] c;
         logic       e;
         logic       r;
         a    = 2'($urandom_range(0, 3));
         c[0] = ($urandom_range(0, 99) < 35);
         c[1] = ($urandom_range(0, 99) < 35);
         e    = ($urandom_range(0, 99) >= 4);
         r    = ($urandom_range(0, 199) == 0);
         cycle(a, c, e, r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_implication_monitor
